// File: rtl/wb_line_master_if.sv
// rtl/wb_line_master_if.sv - line request/response and Wishbone B3 master signal bundle
interface wb_line_master_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [63:0]  req_addr;
    logic [255:0] req_wdata;
    logic [31:0]  req_be;

    logic         rsp_valid;
    logic         rsp_err;
    logic [255:0] rsp_rdata;

    logic [63:0]  wb_adr_o;
    logic [63:0]  wb_dat_o;
    logic [63:0]  wb_dat_i;
    logic [7:0]   wb_sel_o;
    logic         wb_we_o;
    logic         wb_cyc_o;
    logic         wb_stb_o;
    logic         wb_cab_o;
    logic         wb_ack_i;
    logic         wb_err_i;
    logic         wb_rty_i;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready,
        output rsp_valid, rsp_err, rsp_rdata,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cab_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready,
        input  rsp_valid, rsp_err, rsp_rdata,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cab_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_line_master.sv
// rtl/wb_line_master.sv - Wishbone B3 master moving one 256-bit line as four 64-bit beats
module wb_line_master #(
    parameter int TIMEOUT   = 1024,
    parameter int MAX_RETRY = 7,
    parameter int RETRY_GAP = 4
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wb_line_master_if.master   bus
);
    typedef enum logic [1:0] {IDLE, BEAT, GAP, RESP} state_t;

    localparam logic [15:0] TO_LAST   = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST  = (RETRY_GAP <= 1) ? 16'd0 : 16'(RETRY_GAP - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

    state_t       state;
    logic         we_q;
    logic [58:0]  line_q;
    logic [255:0] wdata_q;
    logic [31:0]  be_q;
    logic [1:0]   beat;
    logic [7:0]   retry_cnt;
    logic [15:0]  to_cnt;
    logic [15:0]  gap_cnt;

    logic         hit;
    logic         fail_now;
    logic         ok_now;
    logic [1:0]   next_beat;

    function automatic logic [63:0] beat_dat(input logic [255:0] line, input logic [1:0] b);
        return line[{b, 6'd0} +: 64];
    endfunction

    function automatic logic [7:0] beat_sel(input logic we, input logic [31:0] be, input logic [1:0] b);
        return we ? be[{b, 3'd0} +: 8] : 8'hFF;
    endfunction

    // err beats ack beats rty; a timeout only counts on a cycle with no termination at all
    always_comb begin
        hit       = (state == BEAT) && bus.wb_stb_o;
        next_beat = beat + 2'd1;
        fail_now  = hit && (bus.wb_err_i
                    || (!bus.wb_ack_i && bus.wb_rty_i && retry_cnt == RETRY_LIM)
                    || (!bus.wb_ack_i && !bus.wb_rty_i && TIMEOUT != 0 && to_cnt == TO_LAST));
        ok_now    = hit && !bus.wb_err_i && bus.wb_ack_i && beat == 2'd3;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            line_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            beat          <= 2'd0;
            retry_cnt     <= 8'd0;
            to_cnt        <= 16'd0;
            gap_cnt       <= 16'd0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.wb_adr_o  <= '0;
            bus.wb_dat_o  <= '0;
            bus.wb_sel_o  <= '0;
            bus.wb_we_o   <= 1'b0;
            bus.wb_cyc_o  <= 1'b0;
            bus.wb_stb_o  <= 1'b0;
            bus.wb_cab_o  <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_ready && bus.req_valid) begin
                        we_q          <= bus.req_we;
                        line_q        <= bus.req_addr[63:5];
                        wdata_q       <= bus.req_wdata;
                        be_q          <= bus.req_be;
                        beat          <= 2'd0;
                        retry_cnt     <= 8'd0;
                        to_cnt        <= 16'd0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.req_ready <= 1'b0;
                        bus.wb_adr_o  <= {bus.req_addr[63:5], 2'd0, 3'b000};
                        bus.wb_dat_o  <= beat_dat(bus.req_wdata, 2'd0);
                        bus.wb_sel_o  <= beat_sel(bus.req_we, bus.req_be, 2'd0);
                        bus.wb_we_o   <= bus.req_we;
                        bus.wb_cyc_o  <= 1'b1;
                        bus.wb_stb_o  <= 1'b1;
                        bus.wb_cab_o  <= 1'b1;
                        state         <= BEAT;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end
                BEAT: begin
                    if (hit && !bus.wb_err_i && bus.wb_ack_i && !we_q)
                        bus.rsp_rdata[{beat, 6'd0} +: 64] <= bus.wb_dat_i;
                    if (fail_now || ok_now) begin
                        bus.wb_cyc_o  <= 1'b0;
                        bus.wb_stb_o  <= 1'b0;
                        bus.wb_cab_o  <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= fail_now;
                        state         <= RESP;
                    end else if (bus.wb_ack_i) begin
                        // next beat goes out on the following cycle with no idle gap
                        beat          <= next_beat;
                        to_cnt        <= 16'd0;
                        bus.wb_adr_o  <= {line_q, next_beat, 3'b000};
                        bus.wb_dat_o  <= beat_dat(wdata_q, next_beat);
                        bus.wb_sel_o  <= beat_sel(we_q, be_q, next_beat);
                        bus.wb_cab_o  <= (next_beat != 2'd3);
                    end else if (bus.wb_rty_i) begin
                        retry_cnt     <= retry_cnt + 8'd1;
                        gap_cnt       <= 16'd0;
                        bus.wb_cyc_o  <= 1'b0;
                        bus.wb_stb_o  <= 1'b0;
                        bus.wb_cab_o  <= 1'b0;
                        state         <= GAP;
                    end else begin
                        to_cnt        <= to_cnt + 16'd1;
                    end
                end
                GAP: begin
                    // address/data/sel still hold the retried beat
                    if (gap_cnt == GAP_LAST) begin
                        to_cnt        <= 16'd0;
                        bus.wb_cyc_o  <= 1'b1;
                        bus.wb_stb_o  <= 1'b1;
                        bus.wb_cab_o  <= (beat != 2'd3);
                        state         <= BEAT;
                    end else begin
                        gap_cnt       <= gap_cnt + 16'd1;
                    end
                end
                RESP: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
